// File: rtl/pc_stack_pkg.sv
// Shared sequencer phase encodings, default sizes and branch-condition decode
// for the program-counter / return-stack block.
package pc_stack_pkg;

  typedef enum logic [2:0] {
    RESET_STATE = 3'd0,
    FETCH_INSTR = 3'd1,
    READ_OPS    = 3'd2,
    EXECUTE     = 3'd3,
    WRITEBACK   = 3'd4
  } state_t;

  localparam int PC_WIDTH_DEF    = 8;
  localparam int STACK_DEPTH_DEF = 8;

  localparam logic [1:0] TYPE_CTRL   = 2'b00;
  localparam logic [7:0] COND_NEG    = 8'h00;
  localparam logic [7:0] COND_ZRO    = 8'h01;
  localparam logic [7:0] COND_ALWAYS = 8'h3F;

  // Unknown condition codes never take, even when the invert bit is set.
  function automatic logic cond_take(input logic [7:0] code, input logic inv,
                                     input logic neg, input logic zro);
    logic take;
    case (code)
      COND_NEG:    take = neg ^ inv;
      COND_ZRO:    take = zro ^ inv;
      COND_ALWAYS: take = ~inv;
      default:     take = 1'b0;
    endcase
    return take;
  endfunction

endpackage

// File: rtl/pc_stack_ret_stack.sv
// LIFO of return addresses: push, pop, or replace-top in one cycle.
// Entry contents are not reset; top_o is gated to zero while empty.
module ret_stack
  import pc_stack_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH_DEF,
  parameter int DEPTH = STACK_DEPTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             replace_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] top_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [AW-1:0]    wr_idx, top_idx;

  assign full_o  = (ptr_q == PW'(DEPTH));
  assign empty_o = (ptr_q == '0);
  assign wr_idx  = AW'(ptr_q);
  assign top_idx = AW'(ptr_q - 1'b1);
  assign top_o   = empty_o ? '0 : mem_q[top_idx];

  always_comb begin
    ptr_d = ptr_q;
    if (push_i && !full_o) begin
      ptr_d = ptr_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      ptr_d = ptr_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      if (push_i && !full_o) begin
        mem_q[wr_idx] <= wdata_i;
      end else if (replace_i && !empty_o) begin
        mem_q[top_idx] <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/pc_stack.sv
// Program counter with conditional jump, call/return via ret_stack and a sticky
// overflow/underflow flag; state advances only on the EXECUTE edge.
module pc_stack
  import pc_stack_pkg::*;
#(
  parameter int PC_WIDTH    = PC_WIDTH_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic [2:0]          current_state_i,
  input  logic [31:0]         crnt_instrn_i,
  input  logic                neg_flag_i,
  input  logic                zro_flag_i,
  input  logic                push_enbl_i,
  input  logic                pop_enbl_i,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic                stack_full_o,
  output logic                stack_empty_o,
  output logic                stack_err_o
);

  logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc, target, top;
  logic                err_q, err_d;
  logic                exec, take, jump;
  logic                stk_push, stk_pop, stk_replace;
  logic                unused_instr;

  assign exec   = (current_state_i == EXECUTE);
  assign target = crnt_instrn_i[PC_WIDTH-1:0];
  assign pc_inc = pc_q + 1'b1;
  assign take   = cond_take(crnt_instrn_i[23:16], crnt_instrn_i[25],
                            neg_flag_i, zro_flag_i);
  assign jump   = (crnt_instrn_i[31:30] == TYPE_CTRL) && crnt_instrn_i[29] && take;

  // Call/return decode arrives on the enables; the opcode bits are informational here.
  assign unused_instr = ^{crnt_instrn_i[28:26], crnt_instrn_i[24], crnt_instrn_i[15:8]};

  always_comb begin
    pc_d        = pc_q;
    err_d       = err_q;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_replace = 1'b0;
    if (exec) begin
      if (pop_enbl_i) begin
        if (!stack_empty_o) begin
          pc_d        = top;
          stk_replace = push_enbl_i;
          stk_pop     = !push_enbl_i;
        end else begin
          pc_d  = pc_inc;
          err_d = 1'b1;
        end
      end else if (push_enbl_i) begin
        pc_d     = target;
        stk_push = !stack_full_o;
        err_d    = err_q | stack_full_o;
      end else if (jump) begin
        pc_d = target;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      pc_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  ret_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk_i     (clk_i),
    .rst_ni    (reset_ni),
    .push_i    (stk_push),
    .pop_i     (stk_pop),
    .replace_i (stk_replace),
    .wdata_i   (pc_inc),
    .top_o     (top),
    .full_o    (stack_full_o),
    .empty_o   (stack_empty_o)
  );

  assign pc_o        = pc_q;
  assign stack_err_o = err_q;

endmodule

// File: doc/pc_stack.md
PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 SHALL: PC_WIDTH, default 8, width of program counter and return addresses.
REQ-002 SHALL: STACK_DEPTH, default 8, number of return-address entries.
REQ-003 SHALL: Clk  input  1  CPU clock; all state updates on rising edge.
REQ-004 SHALL: Reset  input  1  one clock; reset is synchronous and active-low.
REQ-005 SHALL: Current_State  input  `State_Type  sequencer phase (RESET_STATE, FETCH_INSTR, READ_OPS, EXECUTE, WRITEBACK).
REQ-006 SHALL: Crnt_Instrn  input  32  latched instruction; [31:30] type, [29] jump, [28] call, [27] return, [25] invert condition, [23:16] condition code, [PC_WIDTH-1:0] target.
REQ-007 SHALL: Neg_Flag, Zro_Flag  input  1 each  latched ALU flags.
REQ-008 SHALL: PushEnbl  input  1  push return address (call taken), valid in EXECUTE.
REQ-009 SHALL: PopEnbl  input  1  pop return address (return), valid in EXECUTE.
REQ-010 SHALL: Pc  output  PC_WIDTH  instruction fetch address, registered.
REQ-011 SHALL: Stack_Full, Stack_Empty  output  1 each  occupancy == STACK_DEPTH / == 0, decoded from registered pointer.
REQ-012 SHALL: Stack_Err  output  1  sticky overflow/underflow flag, registered.

Function
REQ-013 SHALL: Pc, stack pointer and Stack_Err change only on the rising edge at which Current_State == EXECUTE; all other phases hold.
REQ-014 SHALL: Condition: Take = cond(Crnt_Instrn[23:16]) XOR Crnt_Instrn[25], with 0x00 -> Neg_Flag, 0x01 -> Zro_Flag, 0x3F -> 1; any other code -> Take = 0 regardless of [25].
REQ-015 SHALL: Jump = type 00 AND [29] AND Take; Jump SHALL load Pc <= target.
REQ-016 SHALL: PushEnbl (not full) writes Pc+1 (mod 2^PC_WIDTH) at the current pointer, increments pointer, loads Pc <= target.
REQ-017 SHALL: PopEnbl (not empty) decrements pointer, loads Pc <= entry at new pointer.
REQ-018 SHALL: Priority when several apply: PopEnbl > PushEnbl > Jump > sequential.
REQ-019 SHALL: PushEnbl and PopEnbl together (not empty): Pc <= top entry, top entry overwritten with Pc+1, pointer unchanged.
REQ-020 SHALL: Sequential (none of the above): Pc <= Pc+1, wrapping from 2^PC_WIDTH-1 to 0.
REQ-021 SHALL: Push when full: no write, pointer unchanged, Pc <= target, Stack_Err <= 1.
REQ-022 SHALL: Pop when empty (or push+pop when empty): pointer unchanged, Pc <= Pc+1, Stack_Err <= 1.
REQ-023 SHALL: Stack_Err remains 1 until reset.
REQ-024 SHALL: Latency: new Pc visible the cycle after EXECUTE, i.e. during WRITEBACK, stable for the next FETCH_INSTR.
REQ-025 SHALL: Pc not affected by type 01/10/11 instructions other than sequential increment.

Reset
REQ-026 SHALL: Reset low at a rising edge: Pc <= 0, pointer <= 0, Stack_Err <= 0, in any phase including mid-EXECUTE; Stack_Empty = 1, Stack_Full = 0 thereafter.
REQ-027 SHALL: Stack entry contents are not reset; reading is gated by pointer so stale data is never used.

Structure
REQ-028 SHALL: State encodings remain in the shared risc.h; PC_WIDTH and STACK_DEPTH defaults SHALL also be defined there.
REQ-029 SHALL: LIFO storage and pointer in one sub-module ret_stack (push, pop, replace, full, empty, top); pc_stack holds Pc, condition decode and error logic.

Verification
REQ-030 SHALL: Reset low 1 cycle, then 4 NOP (type 00, [29:27]=0) instruction rounds -> Pc = 0,1,2,3,4; Stack_Empty=1.
REQ-031 SHALL: Pc=0x10, jump cond 0x01, [25]=0, Zro_Flag=1, target 0x40 -> Pc=0x40; repeat with [25]=1 -> Pc=0x11.
REQ-032 SHALL: Pc=0x20, PushEnbl, target 0x80 -> Pc=0x80, stack top=0x21; then PopEnbl -> Pc=0x21, Stack_Empty=1.
REQ-033 SHALL: 8 pushes -> Stack_Full=1, Stack_Err=0; 9th push target 0x05 -> Pc=0x05, Stack_Err=1, pointer still 8.
REQ-034 SHALL: Pop with empty stack at Pc=0x30 -> Pc=0x31, Stack_Err=1; Reset low during following EXECUTE -> Pc=0, Stack_Err=0.
REQ-035 SHALL: Pc=0xFF sequential -> Pc=0x00; push+pop together with top=0x50 at Pc=0x60 -> Pc=0x50, top=0x61, pointer unchanged.
